// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and load/store.
// Read responses are routed back to their owner through a fixed-latency tag pipeline.
module mem_port_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int RD_LATENCY    = 1,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [3:0]        ls_be,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [31:0]       ram_rdata
);

  localparam int              SW         = $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_LS_STREAK);
  localparam logic            OWNER_IF   = 1'b0;
  localparam logic            OWNER_LS   = 1'b1;

  logic [SW-1:0]         streak_q, streak_d;
  logic [RD_LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [RD_LATENCY-1:0] tag_owner_q, tag_owner_d;
  logic                  if_elig_s, if_gnt_s, ls_gnt_s, rd_gnt_s;

  // Arbitration: LS first, unless IF has waited through a full LS streak.
  always_comb begin
    if_elig_s = if_req & ~if_flush;
    if_gnt_s  = 1'b0;
    ls_gnt_s  = 1'b0;
    if (reset) begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
    end else if (ls_req && (!if_elig_s || (streak_q != STREAK_MAX))) begin
      ls_gnt_s = 1'b1;
    end else if (if_elig_s) begin
      if_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
    end
    rd_gnt_s = if_gnt_s | (ls_gnt_s & ~ls_we);
  end

  // RAM port mux driven by the granted requester.
  always_comb begin
    ram_en    = if_gnt_s | ls_gnt_s;
    ram_we    = ls_gnt_s & ls_we;
    ram_addr  = '0;
    ram_wdata = 32'h0000_0000;
    ram_be    = 4'h0;
    if (ls_gnt_s) begin
      ram_addr  = ls_addr;
      ram_wdata = ls_wdata;
      ram_be    = ls_we ? ls_be : 4'hF;
    end else if (if_gnt_s) begin
      ram_addr  = if_addr;
      ram_be    = 4'hF;
    end else begin
      ram_addr  = '0;
      ram_be    = 4'h0;
    end
  end

  // Streak counter and tag pipeline next state.
  always_comb begin
    if (!if_elig_s) begin
      streak_d = '0;
    end else if (if_gnt_s) begin
      streak_d = '0;
    end else if (ls_gnt_s && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1);
    end else begin
      streak_d = streak_q;
    end

    tag_valid_d    = '0;
    tag_owner_d    = '0;
    tag_valid_d[0] = rd_gnt_s;
    tag_owner_d[0] = ls_gnt_s ? OWNER_LS : OWNER_IF;
    // A flush only kills IF entries still travelling; the last stage is already visible.
    for (int k = 1; k < RD_LATENCY; k++) begin
      tag_valid_d[k] = tag_valid_q[k-1] & ~(if_flush & (tag_owner_q[k-1] == OWNER_IF));
      tag_owner_d[k] = tag_owner_q[k-1];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q    <= '0;
      tag_valid_q <= '0;
      tag_owner_q <= '0;
    end else begin
      streak_q    <= streak_d;
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
    end
  end

  assign if_gnt    = if_gnt_s;
  assign ls_gnt    = ls_gnt_s;
  assign if_rvalid = tag_valid_q[RD_LATENCY-1] & (tag_owner_q[RD_LATENCY-1] == OWNER_IF);
  assign ls_rvalid = tag_valid_q[RD_LATENCY-1] & (tag_owner_q[RD_LATENCY-1] == OWNER_LS);
  assign if_rdata  = ram_rdata;
  assign ls_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives three arbiters (read latency 1, 2 and 3) with identical stimulus, each with its
// own RAM model; a scoreboard queue holds the responses each lane must return.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  typedef struct {
    int          due;
    int          lane;
    logic        owner;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [15:0] if_addr = 16'h0, ls_addr = 16'h0;
  logic [31:0] ls_wdata = 32'h0;
  logic [3:0]  ls_be = 4'h0;

  logic        if_gnt_w [3], ls_gnt_w [3], if_rvalid_w [3], ls_rvalid_w [3];
  logic        ram_en_w [3], ram_we_w [3];
  logic [31:0] if_rdata_w [3], ls_rdata_w [3], ram_wdata_w [3], ram_rdata_w [3];
  logic [15:0] ram_addr_w [3];
  logic [3:0]  ram_be_w [3];

  exp_t        sb[$];
  logic [31:0] exp_mem [256];
  int          streak_m = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        last_ls_gnt;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int L = g + 1;
    logic [31:0] mem [256];
    logic [31:0] pipe [L];
    logic [7:0]  idx_s;
    logic [31:0] mask_s;
    assign idx_s  = ram_addr_w[g][9:2];
    assign mask_s = {{8{ram_be_w[g][3]}}, {8{ram_be_w[g][2]}}, {8{ram_be_w[g][1]}}, {8{ram_be_w[g][0]}}};
    assign ram_rdata_w[g] = pipe[L-1];

    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
      end else if (ram_en_w[g] && ram_we_w[g]) begin
        mem[idx_s] <= (mem[idx_s] & ~mask_s) | (ram_wdata_w[g] & mask_s);
      end
      pipe[0] <= mem[idx_s];
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end

    mem_port_arbiter #(.ADDR_W(16), .RD_LATENCY(L), .MAX_LS_STREAK(MAX)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt_w[g]), .if_rvalid(if_rvalid_w[g]), .if_rdata(if_rdata_w[g]),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
      .ls_gnt(ls_gnt_w[g]), .ls_rvalid(ls_rvalid_w[g]), .ls_rdata(ls_rdata_w[g]),
      .ram_en(ram_en_w[g]), .ram_we(ram_we_w[g]), .ram_addr(ram_addr_w[g]),
      .ram_wdata(ram_wdata_w[g]), .ram_be(ram_be_w[g]), .ram_rdata(ram_rdata_w[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One bus cycle: drive, predict, check all lanes at the falling edge, then advance the model.
  task automatic step(input logic rst, input logic ifr, input logic [15:0] ifa, input logic fl,
                      input logic lsr, input logic we, input logic [15:0] lsa,
                      input logic [31:0] wd, input logic [3:0] be);
    logic        elig, e_if, e_ls;
    logic [31:0] mask;
    exp_t        e, keep[$];
    bit          found;
    @(posedge clk);
    #1;
    reset = rst; if_req = ifr; if_addr = ifa; if_flush = fl;
    ls_req = lsr; ls_we = we; ls_addr = lsa; ls_wdata = wd; ls_be = be;
    elig = ifr & ~fl;
    e_if = 1'b0;
    e_ls = 1'b0;
    if (!rst) begin
      if (lsr && (!elig || streak_m != MAX)) e_ls = 1'b1;
      else if (elig) e_if = 1'b1;
    end
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("L%0d if_gnt", g + 1), 32'(if_gnt_w[g]), 32'(e_if));
      check_eq($sformatf("L%0d ls_gnt", g + 1), 32'(ls_gnt_w[g]), 32'(e_ls));
      check_eq($sformatf("L%0d ram_en", g + 1), 32'(ram_en_w[g]), 32'(e_if | e_ls));
      check_eq($sformatf("L%0d ram_we", g + 1), 32'(ram_we_w[g]), 32'(e_ls & we));
      check_eq($sformatf("L%0d ram_addr", g + 1), 32'(ram_addr_w[g]),
               32'(e_ls ? lsa : (e_if ? ifa : 16'h0)));
      check_eq($sformatf("L%0d ram_wdata", g + 1), ram_wdata_w[g], e_ls ? wd : 32'h0);
      if (e_if || e_ls)
        check_eq($sformatf("L%0d ram_be", g + 1), 32'(ram_be_w[g]), 32'((e_ls && we) ? be : 4'hF));
      found = 1'b0;
      e = '{due: 0, lane: 0, owner: 1'b0, data: 32'h0};
      foreach (sb[i]) if (sb[i].lane == g && sb[i].due == cyc) begin found = 1'b1; e = sb[i]; end
      check_eq($sformatf("L%0d if_rvalid", g + 1), 32'(if_rvalid_w[g]), 32'(found && !e.owner));
      check_eq($sformatf("L%0d ls_rvalid", g + 1), 32'(ls_rvalid_w[g]), 32'(found && e.owner));
      if (found && !e.owner) check_eq($sformatf("L%0d if_rdata", g + 1), if_rdata_w[g], e.data);
      if (found && e.owner)  check_eq($sformatf("L%0d ls_rdata", g + 1), ls_rdata_w[g], e.data);
    end
    last_ls_gnt = ls_gnt_w[0];
    // Retire delivered entries; reset kills everything still in flight, flush kills IF only.
    foreach (sb[i]) begin
      if (!((sb[i].due <= cyc) || (rst && sb[i].due > cyc) ||
            (fl && !sb[i].owner && sb[i].due > cyc)))
        keep.push_back(sb[i]);
    end
    sb = keep;
    if (e_ls && we) begin
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      exp_mem[lsa[9:2]] = (exp_mem[lsa[9:2]] & ~mask) | (wd & mask);
    end
    if (e_if || (e_ls && !we)) begin
      for (int g = 0; g < 3; g++)
        sb.push_back('{due: cyc + g + 1, lane: g, owner: e_ls,
                       data: exp_mem[e_ls ? lsa[9:2] : ifa[9:2]]});
    end
    if (rst || !elig || e_if) streak_m = 0;
    else if (e_ls && streak_m < MAX) streak_m++;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
  endtask

  initial begin
    logic [11:0] pat;
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'(i);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    mem_init = 1'b0;
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

    // IF-only burst of three fetches
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 16'(4 * i), 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    idle(4);

    // Sustained contention: streak limit lets IF through every fifth cycle
    pat = 12'h0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h0020, 32'h0, 4'h0);
      pat = {pat[10:0], last_ls_gnt};
    end
    check_eq("grant pattern", 32'(pat), 32'(12'b1111_0111_1011));
    idle(4);

    // Full and partial writes followed by read-back
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0040, 32'hDEAD_BEEF, 4'hF);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0044, 32'h1111_2222, 4'h3);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0044, 32'h0, 4'h0);
    idle(4);

    // IF grant, then LS read together with a flush
    step(1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    step(1'b0, 1'b1, 16'h000C, 1'b1, 1'b1, 1'b0, 16'h0004, 32'h0, 4'h0);
    idle(4);

    // Reads in flight across a one-cycle reset, then fresh contention
    step(1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 1'b0, 16'h0050, 32'h0, 4'h0);
    step(1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 1'b0, 16'h0054, 32'h0, 4'h0);
    step(1'b1, 1'b1, 16'h0030, 1'b0, 1'b1, 1'b0, 16'h0058, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 1'b0, 16'h0058, 32'h0, 4'h0);
    idle(4);

    // Alternating IF and LS reads
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, 16'(4 * i), 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
      else step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'(16'h0080 + 4 * i), 32'h0, 4'h0);
    end
    idle(4);

    // Random mix including writes and occasional flushes
    for (int i = 0; i < 60; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255) * 4),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           16'($urandom_range(0, 255) * 4), $urandom, 4'($urandom_range(0, 15)));
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
